// File: rtl/ysyx_041514_commit_trace_pkg.sv
// ysyx_041514_commit_trace_pkg: shared configuration for the commit-trace slice.
// Holds the core width macros (ysyx_041514_XLEN, ysyx_041514_INST_LEN) and the
// commit-record layout widths used by the trace FIFO and its testbench.
// Optional feature macro used elsewhere: YSYX_041514_COMMIT_WATCHDOG_EN.

`ifndef ysyx_041514_XLEN
`define ysyx_041514_XLEN 32
`endif

`ifndef ysyx_041514_INST_LEN
`define ysyx_041514_INST_LEN 32
`endif

// Fixed part of a commit record: {pc, inst}; the sequence tag is appended.
`ifndef ysyx_041514_COMMIT_REC_BASE_W
`define ysyx_041514_COMMIT_REC_BASE_W (`ysyx_041514_XLEN + `ysyx_041514_INST_LEN)
`endif

package ysyx_041514_commit_trace_pkg;

  localparam int XLEN     = `ysyx_041514_XLEN;
  localparam int INST_LEN = `ysyx_041514_INST_LEN;
  localparam int REC_BASE_W = `ysyx_041514_COMMIT_REC_BASE_W;

  // Full record width {pc, inst, seq} for a given sequence-tag width.
  function automatic int rec_width(input int seq_w);
    return REC_BASE_W + seq_w;
  endfunction

endpackage

// File: rtl/ysyx_041514_sync_fifo.sv
// ysyx_041514_sync_fifo: reusable synchronous FIFO, parameterised width/depth.
// Pointers carry one extra MSB so full and empty are distinguishable.
// Read data is the head entry (combinational), valid whenever empty=0.

module ysyx_041514_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the head slot in the same cycle, so push-when-full is legal with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; wraps naturally through the extra MSB.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers alone define which entries are live.
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ysyx_041514_commit_trace.sv
// ysyx_041514_commit_trace: hardware commit log. Queues retired-instruction
// reports {pc, inst, seq} in a FIFO drained by a valid/ready trace sink,
// counts dropped records and tags each commit with a sequence number.
// Optional watchdog: define YSYX_041514_COMMIT_WATCHDOG_EN to enable stall_o.

module ysyx_041514_commit_trace
  import ysyx_041514_commit_trace_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int SEQ_W       = 32,
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                commit_valid_i,
  input  logic [XLEN-1:0]     commit_pc_i,
  input  logic [INST_LEN-1:0] commit_inst_i,
  output logic                trace_valid_o,
  input  logic                trace_ready_i,
  output logic [XLEN-1:0]     trace_pc_o,
  output logic [INST_LEN-1:0] trace_inst_o,
  output logic [SEQ_W-1:0]    trace_seq_o,
  output logic                overflow_o,
  output logic [CNT_W-1:0]    drop_cnt_o,
  output logic                stall_o
);

  localparam int REC_W = rec_width(SEQ_W);

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             drop;
  logic [REC_W-1:0] wdata;
  logic [REC_W-1:0] rdata;
  logic [SEQ_W-1:0] seq_cnt;

  // No bypass: a record pushed into an empty FIFO is only poppable next cycle.
  assign pop   = !fifo_empty && trace_ready_i;
  assign push  = commit_valid_i && (!fifo_full || pop);
  assign drop  = commit_valid_i && fifo_full && !pop;
  assign wdata = {commit_pc_i, commit_inst_i, seq_cnt};

  ysyx_041514_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head fields read as zero while nothing is queued (including after reset).
  assign trace_valid_o = !fifo_empty;
  assign {trace_pc_o, trace_inst_o, trace_seq_o} = fifo_empty ? '0 : rdata;

  // Sequence counter advances on every reported commit, dropped or not.
  always_ff @(posedge clk) begin
    if (rst) seq_cnt <= '0;
    else if (commit_valid_i) seq_cnt <= seq_cnt + 1'b1;
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

`ifdef YSYX_041514_COMMIT_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);

  logic [WDOG_W-1:0] wdog_cnt;

  // Idle-cycle counter: clears on a commit, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst || commit_valid_i) wdog_cnt <= '0;
    else if (wdog_cnt != WDOG_LIMIT) wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign stall_o = (wdog_cnt == WDOG_LIMIT);
`else
  assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_041514_commit_trace.sv
// tb_ysyx_041514_commit_trace: directed, table-driven bench for the commit
// trace block, plus hand-written sequences for full/drain/reset/backpressure
// and watchdog corner cases. Honours YSYX_041514_COMMIT_WATCHDOG_EN.

module tb_ysyx_041514_commit_trace;
  import ysyx_041514_commit_trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int SEQ_W = 32;
  localparam int CNT_W = 16;
  localparam int WDOG  = 16;

`ifdef YSYX_041514_COMMIT_WATCHDOG_EN
  localparam logic WD_ON = 1'b1;
`else
  localparam logic WD_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                commit_valid_i;
  logic [XLEN-1:0]     commit_pc_i;
  logic [INST_LEN-1:0] commit_inst_i;
  logic                trace_valid_o;
  logic                trace_ready_i;
  logic [XLEN-1:0]     trace_pc_o;
  logic [INST_LEN-1:0] trace_inst_o;
  logic [SEQ_W-1:0]    trace_seq_o;
  logic                overflow_o;
  logic [CNT_W-1:0]    drop_cnt_o;
  logic                stall_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_041514_commit_trace #(
    .DEPTH       (DEPTH),
    .SEQ_W       (SEQ_W),
    .CNT_W       (CNT_W),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .commit_valid_i (commit_valid_i),
    .commit_pc_i    (commit_pc_i),
    .commit_inst_i  (commit_inst_i),
    .trace_valid_o  (trace_valid_o),
    .trace_ready_i  (trace_ready_i),
    .trace_pc_o     (trace_pc_o),
    .trace_inst_o   (trace_inst_o),
    .trace_seq_o    (trace_seq_o),
    .overflow_o     (overflow_o),
    .drop_cnt_o     (drop_cnt_o),
    .stall_o        (stall_o)
  );

  typedef struct {
    logic        rst;
    logic        cv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_seq;
    logic [15:0] exp_drop;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] seq;
  } rec_t;

  rec_t model_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    commit_valid_i = 1'b0;
    trace_ready_i = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic commit(input logic cv, input logic [31:0] pc, input logic rdy);
    commit_valid_i = cv;
    commit_pc_i = pc;
    commit_inst_i = pc ^ 32'h0000_0013;
    trace_ready_i = rdy;
  endtask

  task automatic add(input logic r, input logic cv, input logic [31:0] pc, input logic [31:0] inst,
                     input logic rdy, input logic ev, input logic [31:0] epc, input logic [31:0] einst,
                     input logic [31:0] eseq, input logic [15:0] edrop, input logic eovf);
    vec_t v;
    v.rst = r; v.cv = cv; v.pc = pc; v.inst = inst; v.ready = rdy;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_inst = einst; v.exp_seq = eseq;
    v.exp_drop = edrop; v.exp_ovf = eovf;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int popped;
    logic rdy;

    rst = 1'b1;
    commit_valid_i = 1'b0;
    commit_pc_i = '0;
    commit_inst_i = '0;
    trace_ready_i = 1'b0;

    //   rst cv  pc            inst          rdy  valid pc            inst          seq drop ovf
    add(1, 0, 32'h0,        32'h0,        0,  0, 32'h0,        32'h0,        0,  0, 0);
    add(0, 1, 32'h80000000, 32'h00000013, 1,  1, 32'h80000000, 32'h00000013, 0,  0, 0);
    add(0, 1, 32'h80000004, 32'h00100093, 1,  1, 32'h80000004, 32'h00100093, 1,  0, 0);
    add(0, 1, 32'h80000008, 32'h00200113, 1,  1, 32'h80000008, 32'h00200113, 2,  0, 0);
    add(0, 0, 32'h0,        32'h0,        1,  0, 32'h0,        32'h0,        0,  0, 0);
    add(1, 0, 32'h0,        32'h0,        0,  0, 32'h0,        32'h0,        0,  0, 0);
    add(0, 1, 32'h80001000, 32'h10000000, 0,  1, 32'h80001000, 32'h10000000, 0,  0, 0);
    add(0, 1, 32'h80001004, 32'h10000001, 0,  1, 32'h80001000, 32'h10000000, 0,  0, 0);
    add(0, 1, 32'h80001008, 32'h10000002, 0,  1, 32'h80001000, 32'h10000000, 0,  0, 0);
    add(0, 1, 32'h8000100c, 32'h10000003, 0,  1, 32'h80001000, 32'h10000000, 0,  0, 0);
    add(0, 1, 32'h80001010, 32'h10000004, 0,  1, 32'h80001000, 32'h10000000, 0,  0, 0);
    add(0, 1, 32'h80001014, 32'h10000005, 0,  1, 32'h80001000, 32'h10000000, 0,  0, 0);
    add(0, 1, 32'h80001018, 32'h10000006, 0,  1, 32'h80001000, 32'h10000000, 0,  0, 0);
    add(0, 1, 32'h8000101c, 32'h10000007, 0,  1, 32'h80001000, 32'h10000000, 0,  0, 0);
    add(0, 1, 32'h80001020, 32'h10000008, 0,  1, 32'h80001000, 32'h10000000, 0,  1, 1);
    add(0, 1, 32'h80001024, 32'h10000009, 0,  1, 32'h80001000, 32'h10000000, 0,  2, 1);

    // Table: reset state, in-order emission with one-cycle latency, fill and drops.
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      commit_valid_i = vecs[i].cv;
      commit_pc_i = vecs[i].pc;
      commit_inst_i = vecs[i].inst;
      trace_ready_i = vecs[i].ready;
      tick();
      check($sformatf("vec%0d.valid", i), 64'(trace_valid_o), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d.pc", i), 64'(trace_pc_o), 64'(vecs[i].exp_pc));
      check($sformatf("vec%0d.inst", i), 64'(trace_inst_o), 64'(vecs[i].exp_inst));
      check($sformatf("vec%0d.seq", i), 64'(trace_seq_o), 64'(vecs[i].exp_seq));
      check($sformatf("vec%0d.drop", i), 64'(drop_cnt_o), 64'(vecs[i].exp_drop));
      check($sformatf("vec%0d.ovf", i), 64'(overflow_o), 64'(vecs[i].exp_ovf));
      check($sformatf("vec%0d.stall", i), 64'(stall_o), 64'(0));
    end

    // Drain the full FIFO: seq 0..7, then the next commit carries seq 10.
    commit(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d.pc", i), 64'(trace_pc_o), 64'(32'h80001000 + 32'(4 * i)));
      check($sformatf("drain%0d.seq", i), 64'(trace_seq_o), 64'(i));
      tick();
    end
    check("drain.empty", 64'(trace_valid_o), 64'(0));
    commit(1'b1, 32'h80002000, 1'b0);
    tick();
    check("post_drop.seq", 64'(trace_seq_o), 64'(10));
    check("post_drop.ovf_sticky", 64'(overflow_o), 64'(1));

    // Refill to full, then commit+ready together: no drop, occupancy stays full.
    for (int k = 1; k < 8; k++) begin
      commit(1'b1, 32'h80002000 + 32'(4 * k), 1'b0);
      tick();
    end
    check("full.drop", 64'(drop_cnt_o), 64'(2));
    commit(1'b1, 32'h80002020, 1'b1);
    tick();
    check("full_pop_push.drop", 64'(drop_cnt_o), 64'(2));
    check("full_pop_push.head", 64'(trace_seq_o), 64'(11));
    commit(1'b1, 32'h80002024, 1'b0);
    tick();
    check("still_full.drop", 64'(drop_cnt_o), 64'(3));
    commit(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain2_%0d.seq", i), 64'(trace_seq_o), 64'(11 + i));
      tick();
    end
    check("drain2.empty", 64'(trace_valid_o), 64'(0));

    // Reset with 5 records queued discards everything and restarts seq at 0.
    for (int k = 0; k < 5; k++) begin
      commit(1'b1, 32'h80004000 + 32'(4 * k), 1'b0);
      tick();
    end
    check("queued5.valid", 64'(trace_valid_o), 64'(1));
    check("queued5.ovf", 64'(overflow_o), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset.valid", 64'(trace_valid_o), 64'(0));
    check("midreset.ovf", 64'(overflow_o), 64'(0));
    check("midreset.drop", 64'(drop_cnt_o), 64'(0));
    check("midreset.seq", 64'(trace_seq_o), 64'(0));
    commit(1'b1, 32'h80005000, 1'b0);
    tick();
    check("after_reset.seq", 64'(trace_seq_o), 64'(0));
    check("after_reset.pc", 64'(trace_pc_o), 64'(32'h80005000));

    // Backpressure: ready toggles every other cycle, scoreboard tracks the queue.
    do_reset();
    popped = 0;
    for (int c = 0; c < 30; c++) begin
      rdy = c[0];
      commit(c < 6, 32'h80003000 + 32'(4 * c), rdy);
      check($sformatf("bp%0d.valid", c), 64'(trace_valid_o), 64'(model_q.size() > 0));
      if (model_q.size() > 0) begin
        check($sformatf("bp%0d.pc", c), 64'(trace_pc_o), 64'(model_q[0].pc));
        check($sformatf("bp%0d.seq", c), 64'(trace_seq_o), 64'(model_q[0].seq));
      end
      tick();
      if (rdy && model_q.size() > 0) begin
        void'(model_q.pop_front());
        popped++;
      end
      if (c < 6) model_q.push_back('{pc: 32'h80003000 + 32'(4 * c), seq: 32'(c)});
    end
    check("bp.popped", 64'(popped), 64'(6));
    check("bp.drop", 64'(drop_cnt_o), 64'(0));

    // Watchdog: stall after WDOG idle cycles, cleared on the edge after a commit.
    do_reset();
    commit(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < WDOG - 1; k++) tick();
    check("wdog.before", 64'(stall_o), 64'(0));
    tick();
    check("wdog.reached", 64'(stall_o), 64'(WD_ON));
    tick();
    check("wdog.held", 64'(stall_o), 64'(WD_ON));
    commit(1'b1, 32'h80006000, 1'b1);
    #1;
    check("wdog.commit_cycle", 64'(stall_o), 64'(WD_ON));
    tick();
    commit(1'b0, 32'h0, 1'b1);
    check("wdog.cleared", 64'(stall_o), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_041514_commit_trace.md
# ysyx_041514_commit_trace

Receiving end of the writeback commit stream. Each cycle it takes the retired-instruction report (PC, instruction word, valid) and queues it in a small FIFO. A trace sink drains the FIFO through a valid/ready handshake. This gives SoC builds, which have no DPI, a hardware commit log. The block also counts dropped records, tags each record with a sequence number, and optionally flags a commit stall.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `SEQ_W`, 32: sequence-number width.
- `CNT_W`, 16: drop-counter width.
- `WDOG_CYCLES`, 1024: idle cycles before `stall_o` is raised.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `commit_valid_i`  in  1  a retired instruction is reported this cycle.
- `commit_pc_i`  in  `ysyx_041514_XLEN`  retired PC.
- `commit_inst_i`  in  `ysyx_041514_INST_LEN`  retired instruction word.
- `trace_valid_o`  out  1  head record available.
- `trace_ready_i`  in  1  sink accepts the head record.
- `trace_pc_o`  out  `ysyx_041514_XLEN`  head PC.
- `trace_inst_o`  out  `ysyx_041514_INST_LEN`  head instruction.
- `trace_seq_o`  out  `SEQ_W`  head sequence number.
- `overflow_o`  out  1  sticky: at least one record dropped.
- `drop_cnt_o`  out  `CNT_W`  dropped-record count; saturates at all-ones.
- `stall_o`  out  1  watchdog: no commit for `WDOG_CYCLES` cycles.

## Operation
- Reset clears all outputs and state to 0: FIFO empty, `trace_valid_o`=0, `trace_pc_o`/`trace_inst_o`/`trace_seq_o`=0, sequence counter 0, `overflow_o`=0, `drop_cnt_o`=0, `stall_o`=0, watchdog counter 0.
- Push happens when `commit_valid_i`=1 and either the FIFO is not full or a pop occurs in the same cycle.
- The record stores {pc, inst, seq}, with seq taken from the sequence counter.
- The sequence counter increments on every `commit_valid_i` cycle, whether the record is pushed or dropped. Gaps in `trace_seq_o` therefore identify lost records. The counter wraps modulo 2^SEQ_W.
- Drop happens when `commit_valid_i`=1, the FIFO is full, and there is no pop.
  - On a drop, `overflow_o` is set and `drop_cnt_o` increments with saturation.
  - `overflow_o` clears only on reset.
- Pop happens when `trace_valid_o` && `trace_ready_i`. The head advances and the outputs show the next entry, or go invalid.
- `trace_valid_o` = FIFO not empty. The head fields hold stable while `trace_valid_o`=1 and `trace_ready_i`=0.
- Pointers are `$clog2(DEPTH)+1` bits wide; the extra MSB distinguishes full from empty. Pointers wrap naturally.
- A push and a pop in the same cycle leave the occupancy unchanged. This applies at both the full and the empty boundary.
- There is no input-to-output bypass. On an empty FIFO, a push followed by a same-cycle `trace_ready_i` does not pop that record.

## Timing
- Latency: a commit on cycle N appears on `trace_*` at cycle N+1, at the earliest.
- The handshake is standard valid/ready. `trace_valid_o` never drops without a pop, except on reset.
- Throughput: one push and one pop per cycle.
- `overflow_o` and `drop_cnt_o` update on the edge after the drop cycle.
- Reset asserted mid-operation discards all queued records. On the next cycle `trace_valid_o`=0.

## Configuration
- `YSYX_041514_COMMIT_WATCHDOG_EN` defined:
  - The watchdog counter increments each cycle without a commit and clears on any `commit_valid_i`.
  - When the count reaches `WDOG_CYCLES`, `stall_o` goes to 1. It stays at 1 until the next commit, and clears on the edge after that commit.
  - The counter saturates, so it never wraps.
- `YSYX_041514_COMMIT_WATCHDOG_EN` undefined: no watchdog counter exists and `stall_o` is tied to 0.

## Structure
- The width macros (`ysyx_041514_XLEN`, `ysyx_041514_INST_LEN`) come from `sysconfig.v`.
- The record-layout widths belong in that shared header as well.
- The storage is one sub-module, `ysyx_041514_sync_fifo`: a parameterised width/depth FIFO with push, pop, full, and empty. It is reusable elsewhere.
- The top level holds the sequence counter, drop/overflow logic, and watchdog.

## Test plan
- Reset, then 3 commits (pc 0x80000000/04/08) with `trace_ready_i`=1 → three records emitted in order with seq 0,1,2; each appears one cycle after its commit.
- `trace_ready_i`=0 with `DEPTH`+2 = 10 commits → FIFO full after 8; `drop_cnt_o`=2 and `overflow_o`=1. After draining, seq runs 0..7, and the next commit carries seq 10.
- FIFO full, with commit and ready in the same cycle → no drop; occupancy stays 8 and `drop_cnt_o` is unchanged.
- Backpressure: `trace_ready_i` toggles every other cycle → head fields stay stable while stalled, and no record is lost or duplicated.
- Reset asserted with 5 records queued → next cycle `trace_valid_o`=0, `overflow_o`=0, and the next commit gets seq 0.
- Watchdog enabled with `WDOG_CYCLES`=16 and no commits → `stall_o`=1 after 16 idle cycles. One commit clears it on the following edge. With the macro undefined, `stall_o` stays 0.
